// File: rtl/log2_arb_pkg.sv
// Shared types and helpers for the log2 engine arbiter.
package log2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } arb_state_t;

    // LSB position of requester slice idx within a packed operand bus.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/log2_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    int unsigned    j;
    logic [PW-1:0]  pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        pos   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j   = (k + 32'(ptr)) % NREQ;
            pos = PW'(j);
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/log2_arbiter.sv
// Round-robin arbiter sharing one iterative log2 engine among NREQ requesters.
// Optional engine watchdog with result drain: define LOG2_ARB_TIMEOUT_EN.
module log2_arbiter
    import log2_arb_pkg::*;
#(
    parameter  int unsigned M       = 2,
    parameter  int unsigned N       = 5,
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned TIMEOUT = 255,
    localparam int unsigned W       = M + N + 1,
    localparam int unsigned PW      = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_data_i,
    output logic [NREQ-1:0]   rsp_valid_o,
    input  logic [NREQ-1:0]   rsp_ready_i,
    output logic [W-1:0]      rsp_data_o,
    output logic              rsp_err_o,
    output logic              eng_valid_o,
    input  logic              eng_ready_i,
    output logic [W-1:0]      eng_data_o,
    input  logic              eng_res_valid_i,
    output logic              eng_res_ready_o,
    input  logic [W-1:0]      eng_res_data_i,
    output logic              busy_o,
    output logic [PW-1:0]     owner_o
);

    if (NREQ < 2 || TIMEOUT == 0) begin : g_param_check
        $error("log2_arbiter: NREQ must be >= 2 and TIMEOUT must be > 0");
    end

    arb_state_t     state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  owner;
    logic [W-1:0]   operand;
    logic [W-1:0]   result;
    logic           err;
    logic           drain;
    logic           timeout_hit;

    logic [NREQ-1:0] pick_grant;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            grant_en;
    logic            req_hs;
    logic [W-1:0]    ops [NREQ];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            ops[i] = req_data_i[slice_lo(i, W) +: W];
        end
    end

    assign grant_en    = (state == IDLE) && !drain;
    assign req_ready_o = grant_en ? pick_grant : '0;
    assign req_hs      = grant_en && pick_any;

`ifdef LOG2_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
    assign timeout_hit     = (state == WAIT) && !eng_res_valid_i && (cnt == CW'(TIMEOUT - 1));
    assign eng_res_ready_o = (state == WAIT) || drain;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt   <= '0;
            drain <= 1'b0;
        end else begin
            cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (timeout_hit) begin
                drain <= 1'b1;
            end else if (drain && eng_res_valid_i) begin
                drain <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign drain           = 1'b0;
    assign eng_res_ready_o = (state == WAIT);
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            operand <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        operand <= ops[pick_idx];
                        owner   <= pick_idx;
                        // log2(0) is undefined: answer directly without the engine.
                        if (ops[pick_idx] == '0) begin
                            result <= '0;
                            err    <= 1'b1;
                            state  <= DELIVER;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (eng_ready_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_res_valid_i) begin
                        result <= eng_res_data_i;
                        err    <= 1'b0;
                        state  <= DELIVER;
                    end else if (timeout_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (rsp_ready_i[owner]) begin
                        state <= IDLE;
                        ptr   <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_valid_o[i] = (state == DELIVER) && (owner == PW'(i));
        end
    end

    assign eng_valid_o = (state == ISSUE);
    assign eng_data_o  = operand;
    assign rsp_data_o  = result;
    assign rsp_err_o   = err;
    assign busy_o      = (state != IDLE);
    assign owner_o     = owner;

endmodule
